// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package multdiv_unit_pkg;

    localparam int unsigned ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_unit_iter_counter.sv
// Iteration counter: sync clear, count enable, terminal count at ITERS-1.
module iter_counter #(
    parameter int unsigned ITERS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [5:0] count_q;
    logic [5:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 6'(ITERS - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiplier (shift-and-add) / divider (restoring), one bit per cycle.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = multdiv_unit_pkg::ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    import multdiv_unit_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_mul_q, op_mul_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic               start, busy, tc;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;

    assign start = ctrl_MULT | ctrl_DIV;
    assign busy  = (state_q == MUL) || (state_q == DIV);

    iter_counter #(
        .ITERS(ITERS)
    ) u_iter_counter (
        .clk(clock),
        .rst(reset),
        .clr(start),
        .en (busy),
        .tc (tc)
    );

    // Both operations run on magnitudes; the sign is re-applied when the result is registered.
    always_comb begin
        a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_sub   = rem_shift[WIDTH-1:0] - b_q;
        prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_s    = neg_q ? -lo_q : lo_q;
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        op_mul_d = op_mul_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            state_d  = ctrl_MULT ? MUL : DIV;
            op_mul_d = ctrl_MULT;
            hi_d     = '0;
            lo_d     = a_mag;
            b_d      = b_mag;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = (data_operandB == '0);
            ovf_d    = (data_operandA == INT_MIN) && (data_operandB == '1);
        end else begin
            case (state_q)
                MUL: begin
                    // {carry, hi, lo} shifts right; multiplier bits leave lo as product bits enter.
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    if (tc) begin
                        state_d = DONE;
                    end
                end
                DIV: begin
                    hi_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], rem_ge};
                    if (tc) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    if (op_mul_q) begin
                        result_d = prod_s[WIDTH-1:0];
                        exc_d    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                    end else if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quot_s;
                        exc_d    = ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            op_mul_q <= op_mul_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clk;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] result;
    logic        exc;
    logic        rdy;

    int n_checks = 0;
    int n_pass   = 0;

    multdiv_unit #(
        .WIDTH(32),
        .ITERS(32)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (opA),
        .data_operandB (opB),
        .data_result   (result),
        .data_exception(exc),
        .data_resultRDY(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        int                 sa;
        int                 sb;
        longint             p;
        logic signed [31:0] lo;
        sa = a;
        sb = b;
        if (is_mul) begin
            p  = longint'(sa) * longint'(sb);
            lo = p[31:0];
            r  = p[31:0];
            e  = (p != longint'(lo));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 60));
            4:       return -32'($urandom_range(1, 60));
            default: return $urandom;
        endcase
    endfunction

    // Start one operation, scramble operands afterwards, and check latency, strobe count and result.
    task automatic run_op(input bit is_mul, input bit both, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] er;
        logic        ee;
        int          seen;
        int          lat;
        model(is_mul | both, a, b, er, ee);
        @(negedge clk);
        ctrl_MULT = is_mul | both;
        ctrl_DIV  = !is_mul | both;
        opA       = a;
        opB       = b;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        opA       = $urandom;
        opB       = $urandom;
        seen      = 0;
        lat       = 0;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (rdy) begin
                seen++;
                if (seen == 1) begin
                    lat = i;
                    check({tag, "_result"}, 64'(result), 64'(er));
                    check({tag, "_exc"}, 64'(exc), 64'(ee));
                end
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_strobes"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int seen;
        int lat;

        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        opA       = '0;
        opB       = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(result), 64'd0);
        check("reset_exc", 64'(exc), 64'd0);
        check("reset_rdy", 64'(rdy), 64'd0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7_m3");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002, "mul_max_x2");
        run_op(1'b0, 1'b0, 32'hFFFF_FFEC, 32'h0000_0006, "div_m20_6");
        run_op(1'b0, 1'b0, 32'h0000_0005, 32'h0000_0000, "div_by_zero");
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_m1");
        run_op(1'b0, 1'b0, 32'h0000_0064, 32'hFFFF_FFF9, "div_100_m7");

        // Restart: multiply aborted by a divide started 10 cycles later.
        @(negedge clk);
        ctrl_MULT = 1'b1;
        opA       = 32'd3;
        opB       = 32'd4;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clk);
        ctrl_DIV = 1'b1;
        opA      = 32'd100;
        opB      = 32'd10;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        seen     = 0;
        lat      = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy) begin
                seen++;
                if (seen == 1) begin
                    lat = i;
                    check("restart_result", 64'(result), 64'd10);
                    check("restart_exc", 64'(exc), 64'd0);
                end
            end
        end
        check("restart_latency", 64'(lat), 64'd33);
        check("restart_strobes", 64'(seen), 64'd1);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        ctrl_DIV = 1'b1;
        opA      = 32'd1000;
        opB      = 32'd7;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        repeat (13) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_result", 64'(result), 64'd0);
        check("async_rst_exc", 64'(exc), 64'd0);
        check("async_rst_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        check("post_rst_strobes", 64'(seen), 64'd0);

        run_op(1'b1, 1'b0, 32'd2, 32'd3, "mul_2_3");
        run_op(1'b0, 1'b1, 32'd6, 32'd3, "both_ctrl");

        for (int n = 0; n < 24; n++) begin
            run_op($urandom_range(0, 1) == 1, 1'b0, pick(), pick(), $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
